// File: rtl/rv_fetch_exec_units_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_fetch_exec_units_if                                             |
// | Fetch/IMEM-load/ALU signal bundle for rv_fetch_exec_units.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface rv_fetch_exec_units_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output pc, alu_a, alu_b, alu_sel, imem_we, imem_waddr, imem_wdata,
    input  inst, pc_plus4, alu_out
  );

  modport slave (
    input  pc, alu_a, alu_b, alu_sel, imem_we, imem_waddr, imem_wdata,
    output inst, pc_plus4, alu_out
  );
endinterface
`default_nettype wire

// File: rtl/rv_fetch_exec_units.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_fetch_exec_units                                                |
// | RV32I ALU, PC+4 incrementer and word IMEM with a clocked load port.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rv_fetch_exec_units #(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  rv_fetch_exec_units_if.slave bus
);

  localparam int c_AW = $clog2(IMEM_DEPTH);

  localparam logic [3:0] c_OP_ADD   = 4'd0;
  localparam logic [3:0] c_OP_SUB   = 4'd1;
  localparam logic [3:0] c_OP_SLL   = 4'd2;
  localparam logic [3:0] c_OP_SLT   = 4'd3;
  localparam logic [3:0] c_OP_SLTU  = 4'd4;
  localparam logic [3:0] c_OP_XOR   = 4'd5;
  localparam logic [3:0] c_OP_SRL   = 4'd6;
  localparam logic [3:0] c_OP_SRA   = 4'd7;
  localparam logic [3:0] c_OP_OR    = 4'd8;
  localparam logic [3:0] c_OP_AND   = 4'd9;
  localparam logic [3:0] c_OP_PASSB = 4'd10;

  logic              r_ready;
  logic [31:0]       r_mem [IMEM_DEPTH];
  logic [c_AW-1:0]   w_ridx;
  logic [c_AW-1:0]   w_widx;
  logic [4:0]        w_sh;
  logic [31:0]       w_alu;
  logic              w_unused;

  // Word index only: byte offset and bits above the array size are dropped, so addresses wrap.
  assign w_ridx = bus.pc[c_AW+1:2];
  assign w_widx = bus.imem_waddr[c_AW+1:2];
  assign w_sh   = bus.alu_b[4:0];

  assign w_unused = &{1'b0, bus.pc[31:c_AW+2], bus.pc[1:0],
                      bus.imem_waddr[31:c_AW+2], bus.imem_waddr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  // Array has no reset so loaded programs survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (rst_n && bus.imem_we) begin
      r_mem[w_widx] <= bus.imem_wdata;
    end
  end

  assign bus.inst     = r_ready ? r_mem[w_ridx] : NOP_INST;
  assign bus.pc_plus4 = bus.pc + 32'd4;

  always_comb begin
    w_alu = '0;
    case (bus.alu_sel)
      c_OP_ADD:   w_alu = bus.alu_a + bus.alu_b;
      c_OP_SUB:   w_alu = bus.alu_a - bus.alu_b;
      c_OP_SLL:   w_alu = bus.alu_a << w_sh;
      c_OP_SLT:   w_alu = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      c_OP_SLTU:  w_alu = {31'd0, bus.alu_a < bus.alu_b};
      c_OP_XOR:   w_alu = bus.alu_a ^ bus.alu_b;
      c_OP_SRL:   w_alu = bus.alu_a >> w_sh;
      c_OP_SRA:   w_alu = 32'($signed(bus.alu_a) >>> w_sh);
      c_OP_OR:    w_alu = bus.alu_a | bus.alu_b;
      c_OP_AND:   w_alu = bus.alu_a & bus.alu_b;
      c_OP_PASSB: w_alu = bus.alu_b;
      default:    w_alu = '0;
    endcase
  end

  assign bus.alu_out = w_alu;

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_exec_units.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rv_fetch_exec_units                                             |
// | Directed literal checks plus randomized traffic against a model.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rv_fetch_exec_units;

  localparam int          c_DEPTH = 64;
  localparam logic [31:0] c_NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   rand_phase = 1'b0;

  logic [31:0] m_mem [c_DEPTH];
  logic        m_ready = 1'b0;

  rv_fetch_exec_units_if bus ();

  rv_fetch_exec_units #(
    .IMEM_DEPTH (c_DEPTH),
    .NOP_INST   (c_NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: memory as a plain word array, ready as "last edge saw rst_n high".
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready <= 1'b0;
    end else begin
      m_ready <= 1'b1;
      if (bus.imem_we) m_mem[(bus.imem_waddr / 4) % c_DEPTH] <= bus.imem_wdata;
    end
  end

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b % 32);
    r = a;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: for (int i = 0; i < sh; i++) r = r * 2;
      4'd3: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: for (int i = 0; i < sh; i++) r = r / 2;
      4'd7: for (int i = 0; i < sh; i++) r = r / 2 + (a[31] ? 32'h8000_0000 : 32'd0);
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rand_phase) begin
      chk("rand_inst", bus.inst,
          m_ready ? m_mem[(bus.pc / 4) % c_DEPTH] : c_NOP);
      chk("rand_pc_plus4", bus.pc_plus4, bus.pc + 32'd4);
      chk("rand_alu", bus.alu_out, model_alu(bus.alu_sel, bus.alu_a, bus.alu_b));
    end
  end

  task automatic alu_case(input string name, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    bus.alu_sel = sel;
    bus.alu_a = a;
    bus.alu_b = b;
    #1;
    chk(name, bus.alu_out, exp);
  endtask

  initial begin
    bus.pc = 32'd0;
    bus.alu_a = 32'd0;
    bus.alu_b = 32'd0;
    bus.alu_sel = 4'd0;
    bus.imem_we = 1'b0;
    bus.imem_waddr = 32'd0;
    bus.imem_wdata = 32'd0;

    tick();
    tick();
    bus.pc = 32'd8;
    #1 chk("reset_inst_nop", bus.inst, 32'h0000_0013);
    bus.pc = 32'hFFFF_FFFC;
    #1 chk("inc_wrap", bus.pc_plus4, 32'd0);
    chk("reset_inst_nop_hi", bus.inst, 32'h0000_0013);
    bus.pc = 32'd0;
    #1 chk("inc_zero", bus.pc_plus4, 32'd4);

    rst_n = 1'b1;
    bus.pc = 32'd8;
    #1 chk("release_not_yet_ready", bus.inst, 32'h0000_0013);
    tick();

    for (int i = 0; i < c_DEPTH; i++) begin
      bus.imem_we = 1'b1;
      bus.imem_waddr = 32'(i * 4);
      bus.imem_wdata = 32'(i) * 32'h0101_0101;
      tick();
    end
    bus.imem_we = 1'b0;

    bus.pc = 32'd8;
    #1 chk("preload_word2", bus.inst, 32'h0202_0202);
    bus.imem_we = 1'b1;
    bus.imem_waddr = 32'd8;
    bus.imem_wdata = 32'h0050_0093;
    #1 chk("write_cycle_old", bus.inst, 32'h0202_0202);
    tick();
    bus.imem_we = 1'b0;
    #1 chk("write_next_new", bus.inst, 32'h0050_0093);
    bus.pc = 32'd9;
    #1 chk("read_pc9", bus.inst, 32'h0050_0093);
    bus.pc = 32'd8 + 32'd4 * c_DEPTH;
    #1 chk("read_wrap", bus.inst, 32'h0050_0093);

    rst_n = 1'b0;
    bus.pc = 32'd8;
    bus.imem_we = 1'b1;
    bus.imem_wdata = 32'hDEAD_BEEF;
    #1 chk("reset_not_sampled", bus.inst, 32'h0050_0093);
    tick();
    chk("midop_reset_nop", bus.inst, 32'h0000_0013);
    bus.pc = 32'h0000_1234;
    #1 chk("midop_reset_nop_pc", bus.inst, 32'h0000_0013);
    tick();
    bus.imem_we = 1'b0;
    rst_n = 1'b1;
    bus.pc = 32'd8;
    #1 chk("release_still_nop", bus.inst, 32'h0000_0013);
    tick();
    chk("reset_preserved", bus.inst, 32'h0050_0093);

    alu_case("alu_add", 4'd0, 32'd5, 32'd7, 32'd12);
    alu_case("alu_sub", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_case("alu_sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_case("alu_srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_case("alu_sll33", 4'd2, 32'h0000_0003, 32'd33, 32'h0000_0006);
    alu_case("alu_slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_case("alu_sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_case("alu_passb", 4'd10, 32'd1, 32'hABCD_1234, 32'hABCD_1234);
    alu_case("alu_unused13", 4'd13, 32'd5, 32'd7, 32'd0);
    alu_case("alu_xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);

    rand_phase = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 99) >= 4);
      bus.imem_we = ($urandom_range(0, 99) < 35);
      bus.imem_waddr = $urandom;
      bus.imem_wdata = $urandom;
      bus.pc = ($urandom_range(0, 3) == 0) ? bus.imem_waddr : $urandom;
      bus.alu_sel = 4'($urandom_range(0, 15));
      bus.alu_a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 ^ 32'($urandom_range(0, 3)) : $urandom;
      bus.alu_b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    end
    @(posedge clk);
    rand_phase = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
